// File: rtl/fetch_arbiter_pkg.sv
// Shared types for the instruction-fetch arbiter: memory word/address types and FSM states.
// Also provides the pointer-width helper used by the arbiter and its round-robin selector.
package fetch_arbiter_pkg;

  localparam int INSTR_ADDR_W = 32;
  localparam int INSTR_W      = 32;

  typedef logic [INSTR_ADDR_W-1:0] instruction_memory_address_t;
  typedef logic [INSTR_W-1:0]      instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } fetch_arb_state_t;

  // A single requester still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, returns the first set request at or after ptr.
// Kept free of fetch specifics so a data-memory arbiter can reuse it.
module rr_pick
  import fetch_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ptr_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  int         c;
  logic [W-1:0] cand;
  logic       found;

  // Modulo keeps the scan inside 0..N-1 for non-power-of-two counts.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      c    = (int'(ptr) + k) % N;
      cand = W'(c);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fetch_arbiter.sv
// fetch_arbiter: round-robin sharing of one instruction-memory read channel among warp fetchers.
// Stall statistics are built only when FETCH_ARB_STATS_EN is defined.
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  instruction_memory_address_t req_address [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  output instruction_t                req_data,
  output logic                        mem_read_valid,
  output instruction_memory_address_t mem_read_address,
  input  logic                        mem_read_ready,
  input  instruction_t                mem_read_data,
  output logic [31:0]                 stall_cycles
);

  localparam int              PW   = ptr_width(NUM_REQUESTERS);
  localparam logic [PW-1:0]   LAST = PW'(NUM_REQUESTERS - 1);

  fetch_arb_state_t            state, state_next;
  logic [PW-1:0]               rr_ptr, grant_idx, pick_idx;
  logic                        pick_any;
  instruction_memory_address_t addr_q;
  instruction_t                data_q;

  rr_pick #(.N(NUM_REQUESTERS), .W(PW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Outputs decode from state and registers only, so req_valid never reaches mem_read_valid.
  always_comb begin
    state_next     = state;
    mem_read_valid = 1'b0;
    req_ready      = '0;
    case (state)
      IDLE:    if (pick_any) state_next = ISSUE;
      ISSUE: begin
        mem_read_valid = 1'b1;
        if (mem_read_ready) state_next = RESPOND;
      end
      RESPOND: begin
        req_ready  = NUM_REQUESTERS'(1) << grant_idx;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          grant_idx <= pick_idx;
          addr_q    <= req_address[pick_idx];
        end
        ISSUE:   if (mem_read_ready) data_q <= mem_read_data;
        RESPOND: rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + PW'(1);
        default: ;
      endcase
    end
  end

  assign mem_read_address = addr_q;
  assign req_data         = data_q;

`ifdef FETCH_ARB_STATS_EN
  logic [NUM_REQUESTERS-1:0] granted_now;
  logic [31:0]               stall_q;

  // In IDLE the requester about to win is not counted as stalled.
  always_comb begin
    granted_now = '0;
    if (state == IDLE) begin
      if (pick_any) granted_now = NUM_REQUESTERS'(1) << pick_idx;
    end else begin
      granted_now = NUM_REQUESTERS'(1) << grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if ((|(req_valid & ~granted_now)) && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_arbiter.sv
// Self-checking bench for fetch_arbiter: transaction-level model compared every cycle,
// plus directed literal checks for latency, ordering, wait states, reset and wrap-around.
module tb_fetch_arbiter;
  import fetch_arbiter_pkg::*;

  localparam int N = 4;
`ifdef FETCH_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b1;
  logic [N-1:0]                req_valid = '0;
  instruction_memory_address_t req_address [N];
  logic [N-1:0]                req_ready;
  instruction_t                req_data;
  logic                        mem_read_valid;
  instruction_memory_address_t mem_read_address;
  logic                        mem_read_ready = 1'b0;
  instruction_t                mem_read_data = '0;
  logic [31:0]                 stall_cycles;

  logic [2:0]                  r3_valid = '0;
  instruction_memory_address_t r3_address [3];
  logic [2:0]                  r3_ready;
  instruction_t                r3_data;
  logic                        m3_valid;
  instruction_memory_address_t m3_address;
  logic [31:0]                 r3_stall;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit check_en = 1'b0;
  int wait_n = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  fetch_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_address(req_address),
    .req_ready(req_ready), .req_data(req_data), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .stall_cycles(stall_cycles)
  );

  fetch_arbiter #(.NUM_REQUESTERS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(r3_valid), .req_address(r3_address),
    .req_ready(r3_ready), .req_data(r3_data), .mem_read_valid(m3_valid),
    .mem_read_address(m3_address), .mem_read_ready(m3_valid),
    .mem_read_data(m3_address + 32'd1), .stall_cycles(r3_stall)
  );

  function automatic instruction_t mem_word(input instruction_memory_address_t a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: answers after wait_n wait cycles, drives junk data whenever not ready.
  always @(posedge clk) begin
    #1;
    if (mem_read_valid) begin
      mem_read_ready = (wcnt >= wait_n);
      mem_read_data  = mem_read_ready ? mem_word(mem_read_address) : (32'hBAD0_0000 | 32'(wcnt));
      wcnt           = mem_read_ready ? 0 : wcnt + 1;
    end else begin
      mem_read_ready = 1'b0;
      mem_read_data  = 32'hBAD0_FFFF;
      wcnt           = 0;
    end
  end

  // Transaction-level model: who owns the channel, whether its word has arrived, next pointer.
  int                          m_owner = -1;
  bit                          m_done = 1'b0;
  int                          m_ptr = 0;
  int                          m_win;
  logic [N-1:0]                m_g;
  instruction_memory_address_t m_addr = '0;
  instruction_t                m_data = '0;
  longint                      m_stall = 0;

  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int k = 0; k < N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_done = 1'b0; m_ptr = 0; m_addr = '0; m_data = '0; m_stall = 0;
    end else begin
      m_win = pick(req_valid, m_ptr);
      m_g   = '0;
      if (m_owner >= 0) m_g[m_owner] = 1'b1;
      else if (m_win >= 0) m_g[m_win] = 1'b1;
      if (((req_valid & ~m_g) != '0) && (m_stall < 64'hFFFF_FFFF)) m_stall++;
      if (m_owner < 0) begin
        if (m_win >= 0) begin m_owner = m_win; m_addr = req_address[m_win]; end
      end else if (!m_done) begin
        if (mem_read_ready) begin m_data = mem_read_data; m_done = 1'b1; end
      end else begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("req_ready", req_ready, (m_owner >= 0 && m_done) ? (64'd1 << m_owner) : 64'd0);
      checkOutput("mem_read_valid", mem_read_valid, (m_owner >= 0 && !m_done) ? 64'd1 : 64'd0);
      checkOutput("mem_read_address", mem_read_address, m_addr);
      checkOutput("req_data", req_data, m_data);
      checkOutput("stall_cycles", stall_cycles, STATS ? m_stall[31:0] : 32'd0);
    end
  end

  // Pulse and channel monitors feeding the directed checks.
  int                          pulse_val[$];
  int                          pulse_cyc[$];
  instruction_t                pulse_dat[$];
  int                          r3_val[$];
  instruction_t                r3_dat[$];
  int                          mrv_run = 0;
  int                          addr_changes = 0;
  bit                          mrv_prev = 1'b0;
  instruction_memory_address_t mrv_addr = '0;

  always @(negedge clk) begin
    cycle++;
    if (req_ready != '0) begin
      pulse_val.push_back(int'(req_ready)); pulse_cyc.push_back(cycle); pulse_dat.push_back(req_data);
    end
    if (r3_ready != '0) begin
      r3_val.push_back(int'(r3_ready)); r3_dat.push_back(r3_data);
    end
    if (mem_read_valid) begin
      if (mrv_prev && mem_read_address != mrv_addr) addr_changes++;
      mrv_addr = mem_read_address;
      mrv_run++;
    end
    mrv_prev = mem_read_valid;
  end

  function automatic int getPulse(input int i);
    return (i < pulse_val.size()) ? pulse_val[i] : -1;
  endfunction
  function automatic int getPulseCyc(input int i);
    return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1000;
  endfunction
  function automatic instruction_t getPulseData(input int i);
    return (i < pulse_dat.size()) ? pulse_dat[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] v, input logic [2:0] v3, input int cycles);
    req_valid = v;
    r3_valid  = v3;
    repeat (cycles) begin @(posedge clk); #2; end
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    reset_n = 1'b1;
    applyStimulus('0, '0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  int base, base3, t_req;
  int exp_seq [5] = '{1, 2, 4, 8, 1};

  initial begin
    for (int i = 0; i < N; i++) req_address[i] = 32'(32'h10 * (i + 1));
    for (int i = 0; i < 3; i++) r3_address[i] = 32'(32'h100 * (i + 1));
    #1 reset_n = 1'b0;
    check_en = 1'b1;
    @(posedge clk); #2;
    @(negedge clk); #1;
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_mem_read_valid", mem_read_valid, 0);
    checkOutput("reset_mem_read_address", mem_read_address, 0);
    checkOutput("reset_req_data", req_data, 0);
    checkOutput("reset_stall_cycles", stall_cycles, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    applyStimulus('0, '0, 2);

    // Single request, zero-wait memory.
    base = pulse_val.size(); t_req = cycle;
    applyStimulus(4'b0001, '0, 3);
    applyStimulus(4'b0000, '0, 2);
    checkOutput("t1_pulse_count", pulse_val.size() - base, 1);
    checkOutput("t1_grant", getPulse(base), 1);
    checkOutput("t1_latency", getPulseCyc(base) - (t_req + 1), 2);
    checkOutput("t1_data", getPulseData(base), 32'hDEAD_BEEF);
    checkOutput("t1_mem_addr", mrv_addr, 32'h10);

    // Pointer now 1: of fetchers 0 and 1, fetcher 1 wins.
    base = pulse_val.size();
    applyStimulus(4'b0011, '0, 3);
    applyStimulus(4'b0000, '0, 2);
    checkOutput("ptr_after_t1_grant", getPulse(base), 2);

    // All four requesting continuously from a fresh pointer.
    applyReset();
    base = pulse_val.size(); t_req = cycle;
    applyStimulus(4'b1111, '0, 15);
    applyStimulus(4'b0000, '0, 2);
    checkOutput("rr_first_latency", getPulseCyc(base) - (t_req + 1), 2);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("rr_grant_%0d", i), getPulse(base + i), exp_seq[i]);
    for (int i = 1; i < 5; i++)
      checkOutput($sformatf("rr_spacing_%0d", i), getPulseCyc(base + i) - getPulseCyc(base + i - 1), 3);

    // Five memory wait states; pointer is 1 so fetcher 2 wins.
    base = pulse_val.size(); t_req = cycle; mrv_run = 0; addr_changes = 0; wait_n = 5;
    applyStimulus(4'b0100, '0, 8);
    applyStimulus(4'b0000, '0, 2);
    wait_n = 0;
    checkOutput("wait_mrv_cycles", mrv_run, 6);
    checkOutput("wait_latency", getPulseCyc(base) - (t_req + 1), 7);
    checkOutput("wait_grant", getPulse(base), 4);
    checkOutput("wait_data", getPulseData(base), 32'hC0DE_0030);
    checkOutput("wait_addr_stable", addr_changes, 0);

    // Asynchronous reset while a read is outstanding.
    wait_n = 20; base = pulse_val.size();
    applyStimulus(4'b0010, '0, 3);
    checkOutput("arst_pre_mrv", mem_read_valid, 1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_mem_read_valid", mem_read_valid, 0);
    checkOutput("arst_req_ready", req_ready, 0);
    checkOutput("arst_mem_read_address", mem_read_address, 0);
    checkOutput("arst_req_data", req_data, 0);
    req_valid = '0;
    @(posedge clk); #2;
    reset_n = 1'b1; wait_n = 0;
    applyStimulus(4'b1010, '0, 3);
    applyStimulus(4'b0000, '0, 2);
    checkOutput("arst_pulse_count", pulse_val.size() - base, 1);
    checkOutput("arst_grant_from_zero", getPulse(base), 2);

    // Two fetchers requesting for six cycles.
    applyReset();
    applyStimulus(4'b0011, '0, 6);
    applyStimulus(4'b0000, '0, 4);
    checkOutput("stall_count", stall_cycles, STATS ? 6 : 0);

    // Three-requester wrap: pointer 2, requests 101 give 2 then 0.
    applyReset();
    base3 = r3_val.size();
    applyStimulus('0, 3'b010, 3);
    applyStimulus('0, 3'b000, 2);
    applyStimulus('0, 3'b101, 6);
    applyStimulus('0, 3'b000, 2);
    checkOutput("wrap_pulse_count", r3_val.size() - base3, 3);
    checkOutput("wrap_grant_a", (r3_val.size() > base3) ? r3_val[base3] : -1, 2);
    checkOutput("wrap_grant_b", (r3_val.size() > base3 + 1) ? r3_val[base3 + 1] : -1, 4);
    checkOutput("wrap_grant_c", (r3_val.size() > base3 + 2) ? r3_val[base3 + 2] : -1, 1);
    checkOutput("wrap_data_b", (r3_dat.size() > base3 + 1) ? r3_dat[base3 + 1] : 32'hFFFF_FFFF, 32'h301);
    checkOutput("wrap_data_c", (r3_dat.size() > base3 + 2) ? r3_dat[base3 + 2] : 32'hFFFF_FFFF, 32'h101);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_arbiter.md
# fetch_arbiter

Shares one instruction-memory read channel among the per-warp fetchers of a compute core. Sits between the core's `WARPS_PER_CORE` fetch request ports and a single `INSTRUCTION_MEM_NUM_CHANNELS` slot on the gpu top level. Cores can have more warps than channels. Arbitration is round-robin, and exactly one read is outstanding at a time.

## Interface

Parameters:
- `NUM_REQUESTERS`, default 4: number of fetcher ports (normally `WARPS_PER_CORE`).

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQUESTERS`  fetcher i requests a read. Held high until `req_ready[i]`.
- `req_address`  in  `instruction_memory_address_t [NUM_REQUESTERS]`  per-fetcher address. Stable while valid.
- `req_ready`  out  `NUM_REQUESTERS`  one-cycle pulse: `req_data` is valid for fetcher i.
- `req_data`  out  `instruction_t`  returned instruction, shared by all fetchers and qualified by `req_ready`.
- `mem_read_valid`  out  1  read request to instruction memory.
- `mem_read_address`  out  `instruction_memory_address_t`  latched address of the granted fetcher.
- `mem_read_ready`  in  1  memory returns `mem_read_data` this cycle.
- `mem_read_data`  in  `instruction_t`  instruction word.
- `stall_cycles`  out  32  cycles in which at least one request waited ungranted (see Configuration).

## Operation

The block is a three-state FSM: `IDLE`, `ISSUE`, `RESPOND`.

- **IDLE**
  - If any `req_valid` bit is high, select the winner: the first set bit at or after `rr_ptr`, scanning upward with wrap-around.
  - Latch the winner's index into `grant_idx` and its address into `addr_q`, then go to `ISSUE`.
  - If no `req_valid` bit is high, stay in `IDLE`.
- **ISSUE**
  - `mem_read_valid`=1 and `mem_read_address`=`addr_q`.
  - On `mem_read_ready`, latch `mem_read_data` into `data_q` and go to `RESPOND`.
  - Otherwise hold; there is no timeout.
- **RESPOND**
  - `req_ready[grant_idx]`=1 and `req_data`=`data_q`.
  - Set `rr_ptr` to (`grant_idx`+1) mod `NUM_REQUESTERS`, then go to `IDLE`.
- **`rr_ptr` width:** $clog2(`NUM_REQUESTERS`), with a minimum of 1. The wrap at `NUM_REQUESTERS`-1 goes to 0, including for non-power-of-two counts.
- **Request dropped mid-transaction:** if a fetcher drops `req_valid` after being granted, the transaction still completes and the `req_ready` pulse is still issued. The fetcher must ignore it.
- **Other requesters:** new or other requests arriving in `ISSUE` or `RESPOND` are only considered on the next `IDLE` cycle.
- **`req_data` outside `RESPOND`:** holds `data_q` (last value) and is not qualified.

## Timing

- **Reset values:** all outputs 0 (`req_ready`, `req_data`, `mem_read_valid`, `mem_read_address`, `stall_cycles`). FSM=`IDLE`, `rr_ptr`=0, `grant_idx`=0.
- **Reset mid-transaction:** the transaction is abandoned immediately. `mem_read_valid` drops asynchronously and no `req_ready` is issued.
- **Minimum latency:**
  - Cycle 0: `req_valid` is seen in `IDLE`.
  - Cycle 1: `mem_read_valid`=1.
  - If `mem_read_ready` arrives in cycle 1, `req_ready` pulses in cycle 2.
  - Each memory wait cycle adds one cycle.
- **Back-to-back throughput:** one transaction per 3 cycles (`IDLE`→`ISSUE`→`RESPOND`).
- **Output registration:** `req_ready` is never high for more than one consecutive cycle. All outputs come from registers or are decoded purely from FSM state and registers; there is no combinational path from `req_valid` to `mem_read_valid`.

## Configuration

- **`FETCH_ARB_STATS_EN` defined:**
  - `stall_cycles` increments every cycle in which (`req_valid` & ~granted-this-cycle) is nonzero. Here granted-this-cycle means `grant_idx` while in `ISSUE`/`RESPOND`, or the winner while in `IDLE`.
  - The counter saturates at 32'hFFFF_FFFF and clears only on reset.
- **Undefined:** `stall_cycles` is tied to 0 and no counter logic is synthesized. The port is still present.

## Structure

- **Shared package (`gpu_defines.svh` / `common.sv`):**
  - `instruction_memory_address_t` and `instruction_t` (existing).
  - New enum `fetch_arb_state_t` {`IDLE`, `ISSUE`, `RESPOND`}.
- **Sub-module:** `rr_pick`, a combinational round-robin priority selector. Inputs: request vector and pointer. Outputs: index and any-valid. It is reusable by a future data-memory LSU arbiter.

## Test plan

- **Single request, zero-wait memory:** `req_valid`=4'b0001, address 0x10, memory ready on first cycle with data 0xDEADBEEF → `req_ready`=4'b0001 exactly 2 cycles after request, `req_data`=0xDEADBEEF, `rr_ptr`=1.
- **All four requesting continuously:** zero-wait memory → grants in order 0,1,2,3,0, each `req_ready` pulse spaced 3 cycles apart.
- **Memory wait states:** `mem_read_ready` delayed 5 cycles → `mem_read_valid` and `mem_read_address` held stable 6 cycles, `req_ready` at cycle 7.
- **Wrap-around with `NUM_REQUESTERS`=3:** `rr_ptr`=2, requests 3'b101 → grant 2, then grant 0, never an index of 3.
- **Async reset mid-`ISSUE`:** `reset_n` low while `mem_read_valid`=1 → all outputs 0 within the same cycle, no `req_ready`. After release, the next request is served from `rr_ptr`=0.
- **`FETCH_ARB_STATS_EN`:** with 2 fetchers requesting continuously for 6 cycles (zero-wait) → `stall_cycles`=6. With the macro undefined → `stall_cycles`=0.
